// File: rtl/frame_bank_ring.sv
// Multi-bank frame buffer: the pixel stream fills banks round-robin, and completed
// frames stream out in the order they were written over a valid/ready port.
module frame_bank_ring #(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16384,
    parameter  int NUM_BANKS = 4,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int BANK_W    = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pixel_data,
    input  logic              pixel_valid,
    input  logic              pixel_sof,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [BANK_W-1:0] out_bank,
    output logic [BANK_W:0]   frames_ready,
    output logic              pixel_drop,
    output logic [15:0]       drop_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

    logic [DATA_W-1:0]    mem [NUM_BANKS][DEPTH];
    logic [DATA_W-1:0]    rd_q;
    logic [NUM_BANKS-1:0] full, set_mask, clr_mask;
    logic [BANK_W-1:0]    wr_bank, rd_bank;
    logic [ADDR_W-1:0]    wr_addr, wr_ptr;
    logic [ADDR_W:0]      rd_addr;   // one extra bit marks "whole frame issued"
    state_t               state;
    logic                 wr_en, wr_done, rd_issue, accept_last;

    assign wr_en       = pixel_valid && !full[wr_bank];
    assign wr_ptr      = pixel_sof ? '0 : wr_addr;
    assign wr_done     = wr_en && !pixel_sof && (wr_addr == ADDR_W'(DEPTH - 1));
    assign rd_issue    = (state == STREAM) && (!out_valid || out_ready)
                         && (rd_addr <= (ADDR_W + 1)'(DEPTH - 1));
    assign accept_last = (state == STREAM) && out_valid && out_ready && out_last;
    assign out_bank    = rd_bank;
    assign out_data    = out_valid ? rd_q : '0;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        set_mask     = '0;
        clr_mask     = '0;
        frames_ready = '0;
        if (wr_done)     set_mask[wr_bank] = 1'b1;
        if (accept_last) clr_mask[rd_bank] = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++)
            frames_ready = frames_ready + (BANK_W + 1)'(full[i]);
    end

    // NOTE: the pixel array has no reset; clearing it would prevent block-RAM inference,
    // and the full flags already make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_en)    mem[wr_bank][wr_ptr] <= pixel_data;
        if (rd_issue) rd_q <= mem[rd_bank][rd_addr[ADDR_W-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank    <= '0;
            wr_addr    <= '0;
            full       <= '0;
            pixel_drop <= 1'b0;
            drop_count <= '0;
        end else begin
            full       <= (full | set_mask) & ~clr_mask;
            pixel_drop <= 1'b0;
            if (pixel_valid) begin
                if (full[wr_bank]) begin
                    pixel_drop <= 1'b1;
                    if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
                    if (pixel_sof) wr_addr <= '0;
                end else if (pixel_sof) begin
                    wr_addr <= ADDR_W'(1);
                end else if (wr_done) begin
                    wr_addr <= '0;
                    wr_bank <= bank_inc(wr_bank);
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rd_bank   <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (rd_issue) begin
                out_valid <= 1'b1;
                out_last  <= (rd_addr == (ADDR_W + 1)'(DEPTH - 1));
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    rd_addr <= '0;
                    if (full[rd_bank]) state <= STREAM;
                end
                STREAM: begin
                    if (rd_issue) rd_addr <= rd_addr + 1'b1;
                    if (accept_last) begin
                        rd_bank <= bank_inc(rd_bank);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_bank_ring.sv
// Scoreboard bench for frame_bank_ring (DEPTH=16, 4 banks): stimulus queues the
// expected words, an independent monitor compares whatever the DUT presents.
module tb_frame_bank_ring;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int NB     = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] bank;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_sof = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [1:0]  out_bank;
    logic [2:0]  frames_ready;
    logic        pixel_drop;
    logic [15:0] drop_count;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   drop_pulses = 0;
    int   ready_mode = 0;   // 0: hold low, 1: hold high, 2: toggle

    frame_bank_ring #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_BANKS(NB)) dut (
        .clk(clk), .reset_n(reset_n),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_sof(pixel_sof),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_bank(out_bank), .frames_ready(frames_ready),
        .pixel_drop(pixel_drop), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ~out_ready;
        endcase
    end

    always @(negedge clk) if (pixel_drop) drop_pulses++;

    // Monitor: a presented word must match the queue head; it is popped on acceptance.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("out_data", {24'd0, out_data}, {24'd0, q[0].data});
                check("out_last", {31'd0, out_last}, {31'd0, q[0].last});
                check("out_bank", {30'd0, out_bank}, {30'd0, q[0].bank});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        pixel_valid = 1'b1;
        pixel_data  = d;
        pixel_sof   = sof;
        tick();
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    task automatic expect_px(input logic [7:0] d, input logic last, input logic [1:0] bank);
        exp_t e;
        e.data = d;
        e.last = last;
        e.bank = bank;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [1:0] bank, input logic expect_out);
        for (int i = 0; i < DEPTH; i++) begin
            if (expect_out) expect_px(base + 8'(i), i == DEPTH - 1, bank);
            send(base + 8'(i), 1'b0);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check({name, "_drain_timeout"}, q.size(), 0);
        repeat (4) tick();
    endtask

    initial begin
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_out_bank", {30'd0, out_bank}, 0);
        check("rst_frames_ready", {29'd0, frames_ready}, 0);
        check("rst_pixel_drop", {31'd0, pixel_drop}, 0);
        check("rst_drop_count", {16'd0, drop_count}, 0);

        // Basic stream with latency checks around the last written pixel
        ready_mode = 1;
        send_frame(8'h00, 2'd0, 1'b1);
        check("basic_frames_ready_set", {29'd0, frames_ready}, 1);
        check("basic_valid_e0", {31'd0, out_valid}, 0);
        tick();
        check("basic_valid_e1", {31'd0, out_valid}, 0);
        tick();
        check("basic_valid_e2", {31'd0, out_valid}, 1);
        wait_drain("basic");
        check("basic_frames_ready_clr", {29'd0, frames_ready}, 0);

        // Backpressure: 1010 ready pattern over two frames
        do_reset();
        ready_mode = 2;
        send_frame(8'h40, 2'd0, 1'b1);
        send_frame(8'h60, 2'd1, 1'b1);
        wait_drain("backpressure");
        ready_mode = 1;

        // Resync: five stray pixels, then a frame start carrying 0xA0
        do_reset();
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
        expect_px(8'hA0, 1'b0, 2'd0);
        send(8'hA0, 1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            expect_px(8'hA0 + 8'(i), i == DEPTH - 1, 2'd0);
            send(8'hA0 + 8'(i), 1'b0);
        end
        wait_drain("resync");
        check("resync_frames_ready", {29'd0, frames_ready}, 0);

        // Concurrent: frame 1 completes on the edge that accepts frame 0's last word
        do_reset();
        send_frame(8'h10, 2'd0, 1'b1);
        tick();
        tick();
        for (int i = 0; i < DEPTH - 1; i++) begin
            expect_px(8'h80 + 8'(i), 1'b0, 2'd1);
            send(8'h80 + 8'(i), 1'b0);
        end
        check("conc_frames_ready_pre", {29'd0, frames_ready}, 1);
        expect_px(8'h8F, 1'b1, 2'd1);
        send(8'h8F, 1'b0);
        check("conc_frames_ready_post", {29'd0, frames_ready}, 1);
        check("conc_idle_gap", {31'd0, out_valid}, 0);
        tick();
        check("conc_idle_gap2", {31'd0, out_valid}, 0);
        tick();
        check("conc_frame1_start", {31'd0, out_valid}, 1);
        wait_drain("concurrent");

        // Overflow: four frames fill every bank, the fifth is dropped
        do_reset();
        ready_mode = 0;
        send_frame(8'd0,  2'd0, 1'b1);
        send_frame(8'd16, 2'd1, 1'b1);
        send_frame(8'd32, 2'd2, 1'b1);
        send_frame(8'd48, 2'd3, 1'b1);
        check("ovf_frames_ready_full", {29'd0, frames_ready}, 4);
        drop_pulses = 0;
        send_frame(8'd64, 2'd0, 1'b0);
        tick();
        check("ovf_drop_pulses", drop_pulses, 16);
        check("ovf_drop_count", {16'd0, drop_count}, 16);
        check("ovf_frames_ready_hold", {29'd0, frames_ready}, 4);
        ready_mode = 1;
        wait_drain("overflow");
        check("ovf_frames_ready_empty", {29'd0, frames_ready}, 0);

        // Asynchronous reset in the middle of a streamed frame
        send_frame(8'hC0, 2'd0, 1'b1);
        repeat (5) tick();
        check("mid_valid_before", {31'd0, out_valid}, 1);
        #1;
        reset_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 0);
        check("mid_rst_frames_ready", {29'd0, frames_ready}, 0);
        check("mid_rst_drop_count", {16'd0, drop_count}, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH - 1; i++) send(8'hE0 + 8'(i), 1'b0);
        repeat (4) tick();
        check("mid_no_output_partial", {31'd0, out_valid}, 0);
        check("mid_frames_ready_partial", {29'd0, frames_ready}, 0);
        for (int i = 0; i < DEPTH; i++) expect_px(8'hE0 + 8'(i), i == DEPTH - 1, 2'd0);
        send(8'hEF, 1'b0);
        wait_drain("mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
